// File: rtl/varredura_teclado_pkg.sv
// teclado_pkg: shared types and helpers for the keypad scanner.
//   estado_t    - scanner FSM states
//   row_info_t  - decoded row lines: valid flag plus 2-bit row index
//   row_index() - maps an active-low row pattern to its row index;
//                 valid only when exactly one line is low
package teclado_pkg;

    localparam int NUM_LINHAS  = 4;
    localparam int NUM_COLUNAS = 4;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } estado_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } row_info_t;

    // Anything other than a single low line (idle or ghosting) is invalid.
    function automatic row_info_t row_index(input logic [NUM_LINHAS-1:0] rs);
        row_info_t r;
        r.valid = 1'b0;
        r.idx   = 2'd0;
        case (rs)
            4'b1110: begin r.valid = 1'b1; r.idx = 2'd0; end
            4'b1101: begin r.valid = 1'b1; r.idx = 2'd1; end
            4'b1011: begin r.valid = 1'b1; r.idx = 2'd2; end
            4'b0111: begin r.valid = 1'b1; r.idx = 2'd3; end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/varredura_teclado_if.sv
// varredura_teclado_if: key report bus from the scanner to the product selector.
//   linha, coluna - coordinates of the last accepted key (level, held between presses)
//   enable        - one-cycle strobe; coordinates are valid in that cycle and after.
//                   There is no ready: the consumer must take the strobe when it comes.
//   key_held      - high from the enable cycle until the release is debounced
// master modport drives the bus (scanner), slave modport observes it (selector).
interface varredura_teclado_if;
    logic [1:0] linha;
    logic [1:0] coluna;
    logic       enable;
    logic       key_held;

    modport master (output linha, coluna, enable, key_held);
    modport slave  (input  linha, coluna, enable, key_held);
endinterface

// File: rtl/varredura_teclado_sincronizador.sv
// sincronizador: W-bit two-flop synchronizer; resets to all ones (keypad idle level).
//   clk, reset - clock and synchronous active-high reset
//   d          - asynchronous input
//   q          - synchronized output, two cycles behind d
module sincronizador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '1;
            q  <= '1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/varredura_teclado.sv
// varredura_teclado: 4x4 active-low matrix keypad scanner with press/release debounce.
//   clk, reset - clock, synchronous active-high reset
//   rows_n     - keypad rows (active-low, asynchronous)
//   cols_n     - column drive, one-hot active-low
//   tecla      - key report bus (linha, coluna, enable, key_held), master side
//   estado     - current FSM state, for observation
module varredura_teclado
    import teclado_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_LINHAS-1:0]  rows_n,
    output logic [NUM_COLUNAS-1:0] cols_n,
    varredura_teclado_if.master    tecla,
    output estado_t                estado
);

    localparam int MAXC = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int CW   = $clog2(MAXC) + 1;

    logic [NUM_LINHAS-1:0] rs;
    row_info_t             ri;

    estado_t               state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;    // dwell / debounce / release count
    logic [1:0]            c_q, c_d;        // driven column
    logic [NUM_LINHAS-1:0] pat_q, pat_d;    // row pattern captured at sample
    logic [1:0]            lin_q, lin_d;    // row index captured at sample

    logic [NUM_COLUNAS-1:0] cols_q;
    logic [1:0]             linha_q, coluna_q;
    logic                   enable_q, held_q;

    sincronizador #(.W(NUM_LINHAS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows_n),
        .q     (rs)
    );

    assign ri = row_index(rs);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        pat_d   = pat_q;
        lin_d   = lin_q;
        case (state_q)
            SCAN: begin
                if (cnt_q == CW'(SCAN_DIV - 1)) begin
                    cnt_d = '0;
                    if (ri.valid) begin
                        // Column stays frozen until the key is rejected or released.
                        pat_d   = rs;
                        lin_d   = ri.idx;
                        state_d = teclado_pkg::DEBOUNCE;
                    end else begin
                        c_d = c_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            teclado_pkg::DEBOUNCE: begin
                if (rs != pat_q) begin
                    state_d = SCAN;
                    c_d     = c_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EMIT: begin
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
            end
            WAIT_RELEASE: begin
                if (rs != '1) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
                    state_d = SCAN;
                    c_d     = c_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are loaded from the next-state values so that they are
    // registered yet line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SCAN;
            cnt_q    <= '0;
            c_q      <= 2'd0;
            pat_q    <= '1;
            lin_q    <= 2'd0;
            cols_q   <= 4'b1110;
            linha_q  <= 2'd0;
            coluna_q <= 2'd0;
            enable_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            pat_q    <= pat_d;
            lin_q    <= lin_d;
            cols_q   <= ~(4'b0001 << c_d);
            enable_q <= (state_d == EMIT);
            held_q   <= (state_d == EMIT) || (state_d == WAIT_RELEASE);
            if (state_d == EMIT) begin
                linha_q  <= lin_q;
                coluna_q <= c_q;
            end
        end
    end

    assign cols_n         = cols_q;
    assign tecla.linha    = linha_q;
    assign tecla.coluna   = coluna_q;
    assign tecla.enable   = enable_q;
    assign tecla.key_held = held_q;
    assign estado         = state_q;

endmodule

// File: tb/tb_varredura_teclado.sv
// Bench for varredura_teclado: physical keypad model driving rows_n from
// cols_n, directed scenarios plus random press/glitch/short/ghost traffic,
// and a monitor that pops expected coordinates on every enable pulse.
module tb_varredura_teclado;
    import teclado_pkg::*;

    localparam int SD  = 4;
    localparam int DEB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows_n;
    logic [3:0] cols_n;
    estado_t    estado;

    varredura_teclado_if tecla ();

    varredura_teclado #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
        .clk    (clk),
        .reset  (reset),
        .rows_n (rows_n),
        .cols_n (cols_n),
        .tecla  (tecla.master),
        .estado (estado)
    );

    always #5 clk = ~clk;

    // pressed[row][col]: a row reads low when a pressed key sits in a driven column.
    logic [3:0] pressed [4];

    always_comb begin
        rows_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            rows_n[r] = ~|(pressed[r] & ~cols_n);
    end

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] exp_q[$];   // {linha, coluna} expected per enable pulse

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_key(input int r, input int c, input logic v);
        pressed[r][c] = v;
    endtask

    task automatic wait_held(input logic val, input int max, input string name);
        int n = 0;
        while (tecla.key_held !== val && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, tecla.key_held}, {31'd0, val});
    endtask

    task automatic wait_debounce(input int max, input string name);
        int n = 0;
        while (estado !== teclado_pkg::DEBOUNCE && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, {30'd0, estado}, {30'd0, teclado_pkg::DEBOUNCE});
    endtask

    // Monitor: one sample per cycle, 1 time unit after the active edge.
    logic [1:0] prev_l = 2'd0, prev_c = 2'd0, held_col = 2'd0;
    always @(posedge clk) begin
        logic [3:0] e;
        #1;
        if (reset) begin
            prev_l = 2'd0;
            prev_c = 2'd0;
        end else if (tecla.enable) begin
            if (exp_q.size() == 0) begin
                check("unexpected_enable", {28'd0, tecla.linha, tecla.coluna}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pulse_coord", {28'd0, tecla.linha, tecla.coluna}, {28'd0, e});
                check("pulse_held", {31'd0, tecla.key_held}, 32'd1);
                held_col = e[1:0];
            end
            prev_l = tecla.linha;
            prev_c = tecla.coluna;
        end else begin
            check("coord_stable", {28'd0, tecla.linha, tecla.coluna}, {28'd0, prev_l, prev_c});
            if (tecla.key_held)
                check("col_frozen", {28'd0, cols_n}, {28'd0, ~(4'b0001 << held_col)});
        end
    end

    initial begin
        int r, c, r2, kind, n;
        logic [3:0] one;
        for (int i = 0; i < 4; i++) pressed[i] = 4'b0000;

        // Reset and idle scan sequence.
        reset = 1'b1;
        cycles(2);
        check("rst_cols", {28'd0, cols_n}, 32'hE);
        check("rst_enable", {31'd0, tecla.enable}, 32'd0);
        check("rst_held", {31'd0, tecla.key_held}, 32'd0);
        check("rst_coord", {28'd0, tecla.linha, tecla.coluna}, 32'd0);
        check("rst_state", {30'd0, estado}, {30'd0, SCAN});
        reset = 1'b0;
        one = 4'b0001;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            check("idle_scan", {28'd0, cols_n}, {28'd0, ~(one << ((k / SD) % 4))});
        end

        // Long press row 2 / column 1, then release timing and resume column.
        exp_q.push_back({2'd2, 2'd1});
        set_key(2, 1, 1'b1);
        wait_held(1'b1, 100, "press_accept_timeout");
        cycles(150);
        set_key(2, 1, 1'b0);
        n = 0;
        while (tecla.key_held === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("release_latency", n, DEB + 2);
        check("resume_col2", {28'd0, cols_n}, 32'hB);
        cycles(30);

        // Bounce during debounce of row 0 / column 3: rejected, accepted later.
        exp_q.push_back({2'd0, 2'd3});
        set_key(0, 3, 1'b1);
        wait_debounce(60, "bounce_debounce_timeout");
        cycles(2);
        set_key(0, 3, 1'b0);
        cycles(1);
        set_key(0, 3, 1'b1);
        cycles(10);
        check("bounce_rejected", {31'd0, tecla.key_held}, 32'd0);
        wait_held(1'b1, 100, "bounce_accept_timeout");
        cycles(20);
        set_key(0, 3, 1'b0);
        cycles(30);

        // Ghost: rows 1 and 3 in column 0, coordinates keep prior values.
        set_key(1, 0, 1'b1);
        set_key(3, 0, 1'b1);
        cycles(100);
        set_key(1, 0, 1'b0);
        set_key(3, 0, 1'b0);
        check("ghost_coord", {28'd0, tecla.linha, tecla.coluna}, 32'h3);
        check("ghost_held", {31'd0, tecla.key_held}, 32'd0);
        cycles(30);

        // Release glitch of 5 cycles, then full release and re-press.
        exp_q.push_back({2'd2, 2'd1});
        set_key(2, 1, 1'b1);
        wait_held(1'b1, 100, "glitch_accept_timeout");
        cycles(20);
        set_key(2, 1, 1'b0);
        cycles(5);
        set_key(2, 1, 1'b1);
        cycles(20);
        set_key(2, 1, 1'b0);
        wait_held(1'b0, 50, "glitch_release_timeout");
        exp_q.push_back({2'd2, 2'd1});
        set_key(2, 1, 1'b1);
        wait_held(1'b1, 100, "repress_accept_timeout");
        cycles(20);
        set_key(2, 1, 1'b0);
        cycles(30);

        // Reset during debounce discards the press.
        set_key(1, 2, 1'b1);
        wait_debounce(60, "rst_debounce_timeout");
        reset = 1'b1;
        set_key(1, 2, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        check("abort_cols", {28'd0, cols_n}, 32'hE);
        check("abort_enable", {31'd0, tecla.enable}, 32'd0);
        check("abort_held", {31'd0, tecla.key_held}, 32'd0);
        check("abort_coord", {28'd0, tecla.linha, tecla.coluna}, 32'd0);
        cycles(40);

        // Random traffic.
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            case (kind)
                0: begin
                    exp_q.push_back({r[1:0], c[1:0]});
                    set_key(r, c, 1'b1);
                    cycles(60);
                    set_key(r, c, 1'b0);
                end
                1: begin
                    exp_q.push_back({r[1:0], c[1:0]});
                    set_key(r, c, 1'b1);
                    cycles(40);
                    set_key(r, c, 1'b0);
                    cycles(5);
                    set_key(r, c, 1'b1);
                    cycles(20);
                    set_key(r, c, 1'b0);
                end
                2: begin
                    set_key(r, c, 1'b1);
                    cycles($urandom_range(1, 8));
                    set_key(r, c, 1'b0);
                end
                default: begin
                    r2 = (r + $urandom_range(1, 3)) % 4;
                    set_key(r, c, 1'b1);
                    set_key(r2, c, 1'b1);
                    cycles(60);
                    set_key(r, c, 1'b0);
                    set_key(r2, c, 1'b0);
                end
            endcase
            cycles(30);
            check("rand_released", {31'd0, tecla.key_held}, 32'd0);
        end

        cycles(5);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
